aes_pkcs7_padder: RTL
=====================

Name: aes_pkcs7_padder

Overview:
Upstream feeder for the AES input FIFO.
- Accepts a host message of known byte length as a 32-bit word stream.
- Appends PKCS#7 padding to a 16-byte boundary.
- Writes the result into the AES input FIFO, throttled by that FIFO's almost_full flag.
- Sits between the HPS-side CSR/stream logic and the AES FIFO wrapper's write port (i_write_fifoIn / i_data_fifoIn / o_full_fifoIn).

Parameters:
LEN_W, 16, width of the message byte-length input (maximum message length 2^LEN_W-1 bytes).

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_clr  in  1  synchronous clear/abort; same effect as reset, from the control register
i_start  in  1  one-cycle pulse; latches i_len, begins a message
i_len  in  LEN_W  message length in bytes
i_valid  in  1  host data word valid
i_data  in  32  host data word; byte0 = [31:24] (AES big-endian order)
o_ready  out  1  padder accepts i_data this cycle
i_full_fifo  in  1  AES input FIFO almost_full
o_write_fifo  out  1  FIFO write request
o_data_fifo  out  32  FIFO write data
o_busy  out  1  message in progress
o_done  out  1  one-cycle pulse after the last word is written

Behaviour:
- Reset (async, i_rst_n=0) or i_clr=1: state IDLE; o_write_fifo=0, o_data_fifo=0, o_busy=0, o_done=0, all counters 0.
- Latched at i_start (IDLE only; ignored otherwise):
  - L = i_len.
  - pad n = 16 - (L mod 16), range 1..16.
  - data words D = ceil(L/4).
  - total words T = (L+n)/4.
  - Arithmetic widths: LEN_W+1 bits, no overflow.
- States:
  - IDLE -> DATA on i_start if D>0; -> PAD if D=0.
  - DATA -> PAD after the D-th accepted word.
  - PAD -> DONE after word T has been written.
  - DONE -> IDLE after one cycle; o_done=1 in DONE.
- o_ready = (state==DATA) && !i_full_fifo. Combinational; no dependence on i_valid.
- Accept: i_valid && o_ready. o_write_fifo=1 and o_data_fifo valid on the next cycle (registered, latency 1).
- Last data word when L mod 4 = r ≠ 0: bytes 0..r-1 pass through; bytes r..3 are replaced with byte value n.
- PAD state:
  - Each cycle with !i_full_fifo emits one word 4×n.
  - i_full_fifo=1 stalls and writes nothing. Almost_full slack covers the single in-flight registered write.
- L=0: emits 4 words 0x10101010, then done.
- L mod 16 = 0: emits D data words, then 4 words 0x10101010.
- o_busy=1 in DATA, PAD and DONE.
- i_valid while not in DATA: ignored, no effect.
- i_clr mid-message: immediate return to IDLE; the pending registered write is dropped (o_write_fifo=0 next cycle).
- i_start and i_clr in the same cycle: i_clr wins.

Optional Feature:
AES_PAD_BYPASS_EN
- Defined:
  - Adds input i_bypass (1 bit), sampled at i_start.
  - If set: no padding; T = D; the final partial word is zero-filled for bytes r..3; DATA -> DONE directly.
  - L=0 with bypass: IDLE -> DONE with no writes.
  - Used for decryption payloads that are already block-aligned.
- Undefined: port absent; padding is always applied.

Decomposition:
- Shared package aes_pkg:
  - state enum {IDLE, DATA, PAD, DONE}
  - AES_BLOCK_BYTES=16, AES_WORD_BYTES=4
  - function pkcs7_pad_len(len) returning 1..16
- Sub-module aes_pad_mask: combinational last-word byte merger (inputs: word, r, n, bypass); reused by the unpad checker later.
- Counters and FSM stay in the top module.

Test Plan:
- L=5, words 0x11223344, 0x55xxxxxx, i_full_fifo=0 -> FIFO receives 0x11223344, 0x550B0B0B, 0x0B0B0B0B, 0x0B0B0B0B; o_done one cycle after the 4th write.
- L=16, 4 host words -> 8 writes; last 4 = 0x10101010; o_ready low after the 4th accept.
- L=0 -> exactly 4 writes of 0x10101010, no o_ready assertion.
- L=20, i_full_fifo pulsed high 3 cycles during PAD -> no writes while high; output sequence identical to the unstalled run, 8 words total.
- i_clr asserted after the 2nd accepted word of L=32 -> o_write_fifo=0 next cycle, o_busy=0; a fresh i_start L=4 then yields 4 correct words.
- With AES_PAD_BYPASS_EN, i_bypass=1, L=6, words 0xAABBCCDD, 0xEEFFxxxx -> writes 0xAABBCCDD, 0xEEFF0000 only; o_done follows.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared state encoding, block/word sizes and the PKCS#7 pad-length
// helper used by the AES stream front-end blocks (padder, later unpad checker).
package aes_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PAD,
      DONE
   } state_t;

   localparam int AES_BLOCK_BYTES = 16;
   localparam int AES_WORD_BYTES  = 4;

   // Pad length from the low four bits of a byte length: 16 - (len mod 16), so 1..16.
   function automatic logic [4:0] pkcs7_pad_len(input logic [3:0] len_lo);
      return 5'(AES_BLOCK_BYTES) - {1'b0, len_lo};
   endfunction

endpackage

// File: rtl/aes_pkcs7_padder_if.sv
// aes_pkcs7_padder_if: host word stream in, AES input FIFO write port out.
// slave = the padder side, master = the host/FIFO side driving it.
interface aes_pkcs7_padder_if;

   logic        i_valid;
   logic [31:0] i_data;
   logic        o_ready;
   logic        i_full_fifo;
   logic        o_write_fifo;
   logic [31:0] o_data_fifo;

   modport slave (
      input  i_valid, i_data, i_full_fifo,
      output o_ready, o_write_fifo, o_data_fifo
   );

   modport master (
      output i_valid, i_data, i_full_fifo,
      input  o_ready, o_write_fifo, o_data_fifo
   );

endinterface

// File: rtl/aes_pad_mask.sv
// aes_pad_mask: combinational last-word byte merger. Keeps bytes 0..r-1
// (byte0 = [31:24]) and fills bytes r..3 with the pad value n, or with zero
// when bypassing. r = 0 means a full word and passes it through untouched.
module aes_pad_mask
   import aes_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_r,
   input  logic [4:0]  i_n,
   input  logic        i_bypass,
   output logic [31:0] o_word
);

   logic [7:0] fill;

   // Per-byte select between host data and the fill byte.
   always_comb begin
      // NOTE: every output gets a default before the conditional overrides, so no latch is inferred.
      fill   = i_bypass ? 8'h00 : {3'b000, i_n};
      o_word = i_word;
      for (int b = 0; b < AES_WORD_BYTES; b++) begin
         if ((i_r != 2'd0) && (b >= int'(i_r))) begin
            o_word[31-8*b -: 8] = fill;
         end
      end
   end

endmodule

// File: rtl/aes_pkcs7_padder.sv
// aes_pkcs7_padder: takes a host message of known byte length as 32-bit words,
// appends PKCS#7 padding up to a 16-byte boundary and writes the result into
// the AES input FIFO, throttled by its almost_full flag. Write data is
// registered (one cycle after acceptance).
// Optional build macro AES_PAD_BYPASS_EN adds i_bypass: no padding, the final
// partial word is zero-filled and the message ends after its data words.
module aes_pkcs7_padder
   import aes_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic              i_start,
   input  logic [LEN_W-1:0]  i_len,
`ifdef AES_PAD_BYPASS_EN
   input  logic              i_bypass,
`endif
   output logic              o_busy,
   output logic              o_done,
   aes_pkcs7_padder_if.slave bus
);

   localparam int CW = LEN_W + 1;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;       // words issued so far (data then pad)
   logic [CW-1:0] dw_q, dw_d;         // data words D
   logic [CW-1:0] tw_q, tw_d;         // total words T
   logic [1:0]    rem_q, rem_d;       // L mod 4
   logic [4:0]    pad_q, pad_d;       // pad byte value n
   logic          bypass_q, bypass_d;
   logic          write_q, write_d;
   logic [31:0]   data_q, data_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [CW-1:0] len_ext, start_dw, start_tw, cnt_inc;
   logic [4:0]    start_pad;
   logic          start_byp;
   logic          accept, last_word;
   logic [31:0]   masked;

`ifdef AES_PAD_BYPASS_EN
   assign start_byp = i_bypass;
`else
   assign start_byp = 1'b0;
`endif

   // Message geometry derived from i_len at start, in LEN_W+1 bits.
   always_comb begin
      len_ext   = {1'b0, i_len};
      start_pad = pkcs7_pad_len(i_len[3:0]);
      start_dw  = (len_ext + CW'(AES_WORD_BYTES - 1)) >> 2;
      start_tw  = start_byp ? start_dw : ((len_ext + CW'(start_pad)) >> 2);
   end

   assign bus.o_ready = (state_q == DATA) && !bus.i_full_fifo;
   assign accept      = bus.i_valid && bus.o_ready;
   assign cnt_inc     = cnt_q + CW'(1);
   assign last_word   = (cnt_inc == dw_q);

   aes_pad_mask u_mask (
      .i_word   (bus.i_data),
      .i_r      (last_word ? rem_q : 2'd0),
      .i_n      (pad_q),
      .i_bypass (bypass_q),
      .o_word   (masked)
   );

   // FSM, word counter and the registered FIFO write; i_clr overrides everything.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dw_d     = dw_q;
      tw_d     = tw_q;
      rem_d    = rem_q;
      pad_d    = pad_q;
      bypass_d = bypass_q;
      write_d  = 1'b0;
      data_d   = data_q;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               dw_d     = start_dw;
               tw_d     = start_tw;
               rem_d    = i_len[1:0];
               pad_d    = start_pad;
               bypass_d = start_byp;
               cnt_d    = '0;
               if (start_dw != '0) state_d = DATA;
               else if (start_byp) state_d = DONE;
               else                state_d = PAD;
            end
         end
         DATA: begin
            if (accept) begin
               cnt_d   = cnt_inc;
               write_d = 1'b1;
               data_d  = masked;
               if (last_word) state_d = bypass_q ? DONE : PAD;
            end
         end
         PAD: begin
            // The cycle with cnt == T is the one in which word T reaches the FIFO.
            if (cnt_q == tw_q) begin
               state_d = DONE;
            end else if (!bus.i_full_fifo) begin
               cnt_d   = cnt_inc;
               write_d = 1'b1;
               data_d  = {4{3'b000, pad_q}};
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (i_clr) begin
         state_d  = IDLE;
         cnt_d    = '0;
         dw_d     = '0;
         tw_d     = '0;
         rem_d    = '0;
         pad_d    = '0;
         bypass_d = 1'b0;
         write_d  = 1'b0;
         data_d   = '0;
      end
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         dw_q     <= '0;
         tw_q     <= '0;
         rem_q    <= '0;
         pad_q    <= '0;
         bypass_q <= 1'b0;
         write_q  <= 1'b0;
         data_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dw_q     <= dw_d;
         tw_q     <= tw_d;
         rem_q    <= rem_d;
         pad_q    <= pad_d;
         bypass_q <= bypass_d;
         write_q  <= write_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.o_write_fifo = write_q;
   assign bus.o_data_fifo  = data_q;
   assign o_busy           = busy_q;
   assign o_done           = done_q;

endmodule
